// File: rtl/modbus_poller_if.sv
// modbus_poller_if: bundles the poller's transceiver and report signals.
//   tx_frame     72  frame presented to the transceiver data_out
//   tx_busy       1  transceiver tx_en
//   rx_frame     72  transceiver data_in, [7:0] = received byte count
//   rx_strobe     1  end-of-packet pulse qualifying rx_frame
//   resp_data    72  last captured response frame
//   resp_slot     4  slot index of the last report
//   resp_valid    1  one-cycle pulse: response captured
//   resp_timeout  1  one-cycle pulse: slot timed out
// master = poller side, slave = transceiver / consumer side.
interface modbus_poller_if;
  logic [71:0] tx_frame;
  logic        tx_busy;
  logic [71:0] rx_frame;
  logic        rx_strobe;
  logic [71:0] resp_data;
  logic [3:0]  resp_slot;
  logic        resp_valid;
  logic        resp_timeout;

  modport master (
    output tx_frame, resp_data, resp_slot, resp_valid, resp_timeout,
    input  tx_busy, rx_frame, rx_strobe
  );

  modport slave (
    input  tx_frame, resp_data, resp_slot, resp_valid, resp_timeout,
    output tx_busy, rx_frame, rx_strobe
  );
endinterface

// File: rtl/modbus_poller.sv
// modbus_poller: round-robin Modbus request scheduler. Launches each enabled
// slot's pre-built frame for one cycle, waits for the transmission to drain,
// waits for a response (or times out), reports it tagged with the slot index,
// then holds an inter-frame gap before moving to the next slot.
// Ports:
//   clk         system clock
//   reset       synchronous active-high reset
//   enable      polling enable, sampled only while idle
//   req_frames  Slots x 72-bit request frames, slot k at [k*72 +: 72]
//   busy        high in every state except IDLE
//   bus         transceiver / report signals (modbus_poller_if.master)
module modbus_poller #(
  parameter int unsigned Slots         = 4,
  parameter int unsigned TimeoutCycles = 120000,
  parameter int unsigned GapCycles     = 48000,
  parameter int unsigned TxIdleCycles  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [Slots*72-1:0]   req_frames,
  output logic                  busy,
  modbus_poller_if.master       bus
);

  localparam int unsigned FrameW   = 72;
  localparam int unsigned PtrW     = 4;
  localparam int unsigned MaxSlots = 16;
  localparam int unsigned TimerMax = (TimeoutCycles > GapCycles) ? TimeoutCycles : GapCycles;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);
  localparam int unsigned IdleW    = $clog2(TxIdleCycles + 1);

  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TimeoutCycles - 1);
  localparam logic [TimerW-1:0] GapLast     = TimerW'(GapCycles - 1);
  localparam logic [IdleW-1:0]  IdleLast    = IdleW'(TxIdleCycles - 1);
  localparam logic [PtrW-1:0]   PtrLast     = PtrW'(Slots - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_TX,
    WAIT_RX,
    GAP
  } state_t;

  state_t            state;
  logic [PtrW-1:0]   ptr;
  logic [TimerW-1:0] timer;
  logic [IdleW-1:0]  idleCnt;
  logic              sawBusy;

  // Slot table padded to 16 entries so the 4-bit pointer indexes it exactly.
  logic [FrameW-1:0] slotFrame [MaxSlots];
  for (genvar k = 0; k < int'(MaxSlots); k++) begin : gSlot
    if (k < int'(Slots)) begin : gUsed
      assign slotFrame[k] = req_frames[k*FrameW +: FrameW];
    end else begin : gUnused
      assign slotFrame[k] = '0;
    end
  end

  logic [FrameW-1:0] curFrame;
  logic [PtrW-1:0]   ptrNext;
  logic [TimerW-1:0] timerInc;
  logic [IdleW-1:0]  idleInc;
  logic              rxHit;

  assign curFrame = slotFrame[ptr];
  assign ptrNext  = (ptr == PtrLast) ? '0 : ptr + PtrW'(1);
  assign timerInc = (timer == '1) ? timer : timer + TimerW'(1);
  assign idleInc  = (idleCnt == '1) ? idleCnt : idleCnt + IdleW'(1);
  // Only a strobe carrying a nonzero byte count counts as a response.
  assign rxHit    = bus.rx_strobe && (bus.rx_frame[7:0] != 8'd0);

  // Scheduler state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      ptr              <= '0;
      timer            <= '0;
      idleCnt          <= '0;
      sawBusy          <= 1'b0;
      busy             <= 1'b0;
      bus.tx_frame     <= '0;
      bus.resp_data    <= '0;
      bus.resp_slot    <= '0;
      bus.resp_valid   <= 1'b0;
      bus.resp_timeout <= 1'b0;
    end else begin
      bus.resp_valid   <= 1'b0;
      bus.resp_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            if (curFrame[3:0] != 4'd0) begin
              // tx_frame doubles as the in-flight copy of the slot frame.
              state        <= SEND;
              bus.tx_frame <= curFrame;
              busy         <= 1'b1;
              timer        <= '0;
            end else begin
              ptr <= ptrNext;
            end
          end
        end
        SEND: begin
          state        <= WAIT_TX;
          bus.tx_frame <= '0;
          timer        <= '0;
          idleCnt      <= '0;
          sawBusy      <= 1'b0;
        end
        WAIT_TX: begin
          if (!sawBusy) begin
            // Timeout applies only until the transmitter has started.
            if (bus.tx_busy) begin
              sawBusy <= 1'b1;
              idleCnt <= '0;
            end else if (timer == TimeoutLast) begin
              bus.resp_timeout <= 1'b1;
              bus.resp_slot    <= ptr;
              state            <= GAP;
              timer            <= '0;
            end else begin
              timer <= timerInc;
            end
          end else if (bus.tx_busy) begin
            idleCnt <= '0;
          end else if (idleCnt == IdleLast) begin
            state <= WAIT_RX;
            timer <= '0;
          end else begin
            idleCnt <= idleInc;
          end
        end
        WAIT_RX: begin
          // A response in the expiry cycle still wins over the timeout.
          if (rxHit) begin
            bus.resp_data  <= bus.rx_frame;
            bus.resp_slot  <= ptr;
            bus.resp_valid <= 1'b1;
            state          <= GAP;
            timer          <= '0;
          end else if (timer == TimeoutLast) begin
            bus.resp_timeout <= 1'b1;
            bus.resp_slot    <= ptr;
            state            <= GAP;
            timer            <= '0;
          end else begin
            timer <= timerInc;
          end
        end
        GAP: begin
          if (timer == GapLast) begin
            ptr   <= ptrNext;
            state <= IDLE;
            busy  <= 1'b0;
            timer <= '0;
          end else begin
            timer <= timerInc;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_poller.sv
// tb_modbus_poller: directed, table-driven bench for modbus_poller using short
// timeout/gap values. Inputs are driven and outputs sampled on the falling edge.
module tb_modbus_poller;
  localparam int unsigned Slots   = 4;
  localparam int unsigned Timeout = 200;
  localparam int unsigned Gap     = 50;
  localparam int unsigned TxIdle  = 8;

  logic                clk;
  logic                reset;
  logic                enable;
  logic                busy;
  logic [Slots*72-1:0] req_frames;

  modbus_poller_if bus ();

  modbus_poller #(
    .Slots        (Slots),
    .TimeoutCycles(Timeout),
    .GapCycles    (Gap),
    .TxIdleCycles (TxIdle)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .req_frames(req_frames),
    .busy      (busy),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          slot;
    int          busyLen;   // 0 = tx_busy stuck low
    int          rxDelay;   // strobe offset from reference cycle, -1 = none
    logic [71:0] rxFrame;
    logic        expValid;  // 1 = resp_valid expected, 0 = resp_timeout
    int          expOff;    // report cycle offset from reference cycle
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int respPulses = 0;
  int expReports = 0;
  int expLaunchAt = 0;
  int gapExtra = 0;
  bit launchOk;
  logic [71:0] lastData;
  logic [71:0] frames [Slots];
  vec_t vecs [6];

  localparam logic [71:0] StrayFrame = 72'h0000_0000_0000_0000_07;

  // Reference cycle count and count of report pulses seen.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.resp_valid || bus.resp_timeout) respPulses <= respPulses + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic loadFrames();
    for (int k = 0; k < int'(Slots); k++) req_frames[k*72 +: 72] = frames[k];
  endtask

  task automatic waitLaunch(input int slot);
    int n = 0;
    while (bus.tx_frame[3:0] == 4'd0 && n < 2000) begin
      tick();
      n++;
    end
    launchOk = (bus.tx_frame[3:0] != 4'd0);
    check("launch_seen", 72'(launchOk), 72'(1));
    if (launchOk) begin
      check("launch_cycle", 72'(cyc), 72'(expLaunchAt));
      check("launch_frame", bus.tx_frame, frames[slot]);
      check("busy_in_send", 72'(busy), 72'(1));
      check("no_stray_report", 72'(respPulses), 72'(expReports));
    end
  endtask

  task automatic runVec(input vec_t v);
    int reportCyc;
    waitLaunch(v.slot);
    if (!launchOk) return;
    tick();
    check("send_one_cycle", bus.tx_frame, 72'(0));
    if (v.busyLen > 0) begin
      bus.tx_busy = 1'b1;
      repeat (v.busyLen) tick();
      bus.tx_busy = 1'b0;
    end
    for (int off = 0; off <= v.expOff; off++) begin
      if (off > 0) tick();
      bus.rx_strobe = (off == v.rxDelay);
      if (off == v.rxDelay) bus.rx_frame = v.rxFrame;
      if (off == v.expOff - 1)
        check("no_early_report", 72'({bus.resp_valid, bus.resp_timeout}), 72'(0));
    end
    reportCyc = cyc;
    check("report_count", 72'(respPulses), 72'(expReports));
    check("resp_valid", 72'(bus.resp_valid), 72'(v.expValid));
    check("resp_timeout", 72'(bus.resp_timeout), 72'(!v.expValid));
    check("resp_slot", 72'(bus.resp_slot), 72'(v.slot));
    if (v.expValid) lastData = v.rxFrame;
    check("resp_data", bus.resp_data, lastData);
    expReports++;
    bus.rx_strobe = 1'b0;
    // A late reply during the gap must be discarded.
    repeat (5) tick();
    bus.rx_frame  = StrayFrame;
    bus.rx_strobe = 1'b1;
    tick();
    bus.rx_strobe = 1'b0;
    expLaunchAt = reportCyc + Gap + gapExtra;
  endtask

  initial begin
    vec_t va;
    reset         = 1'b1;
    enable        = 1'b0;
    req_frames    = '0;
    bus.tx_busy   = 1'b0;
    bus.rx_strobe = 1'b0;
    bus.rx_frame  = '0;
    lastData      = '0;
    tick();
    tick();

    check("rst_tx_frame", bus.tx_frame, 72'(0));
    check("rst_resp_data", bus.resp_data, 72'(0));
    check("rst_resp_slot", 72'(bus.resp_slot), 72'(0));
    check("rst_resp_valid", 72'(bus.resp_valid), 72'(0));
    check("rst_resp_timeout", 72'(bus.resp_timeout), 72'(0));
    check("rst_busy", 72'(busy), 72'(0));

    // Only slot 0 enabled: disabled slots are scanned one per cycle.
    frames[0] = 72'h0000_0000_0000_0301_02;
    frames[1] = '0;
    frames[2] = '0;
    frames[3] = '0;
    loadFrames();
    reset       = 1'b0;
    enable      = 1'b1;
    expLaunchAt = cyc + 1;
    gapExtra    = 4;
    va = '{0, 40, 100, 72'h00_0000_B5B4_B3B2_B1_05, 1'b1, 101};
    runVec(va);
    waitLaunch(0);

    // All four slots enabled with distinct frames.
    reset     = 1'b1;
    frames[0] = 72'h0000_0000_0000_2211_02;
    frames[1] = 72'h0000_0000_0043_3221_03;
    frames[2] = 72'hA8A7_A6A5_A4A3_A2A1_08;
    frames[3] = 72'h0000_0000_0000_005A_01;
    loadFrames();
    tick();
    check("rst_mid_tx_frame", bus.tx_frame, 72'(0));
    reset       = 1'b0;
    lastData    = '0;
    expLaunchAt = cyc + 1;
    gapExtra    = 1;

    vecs[0] = '{0, 30,  20, 72'h0000_0000_00C3_C2C1_03, 1'b1,  21};
    vecs[1] = '{1, 25,  -1, 72'h0000_0000_0000_0000_00, 1'b0, 208};
    vecs[2] = '{2, 20,  50, 72'hD8D7_D6D5_D4D3_D2D1_08, 1'b1,  51};
    vecs[3] = '{3,  0,  10, 72'h0000_0000_0000_00EE_01, 1'b0, 200};
    vecs[4] = '{0, 15, 207, 72'h0000_E6E5_E4E3_E2E1_06, 1'b1, 208};
    vecs[5] = '{1, 12,  20, 72'h0000_0000_0000_00FF_00, 1'b0, 208};
    for (int i = 0; i < 6; i++) runVec(vecs[i]);

    // Reset while slot 2 waits for its response.
    waitLaunch(2);
    if (launchOk) begin
      tick();
      bus.tx_busy = 1'b1;
      repeat (10) tick();
      bus.tx_busy = 1'b0;
      repeat (20) tick();
      check("busy_before_reset", 72'(busy), 72'(1));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst2_busy", 72'(busy), 72'(0));
      check("rst2_tx_frame", bus.tx_frame, 72'(0));
      check("rst2_resp_data", bus.resp_data, 72'(0));
      check("rst2_resp_slot", 72'(bus.resp_slot), 72'(0));
      check("rst2_resp_valid", 72'(bus.resp_valid), 72'(0));
      check("rst2_resp_timeout", 72'(bus.resp_timeout), 72'(0));
      tick();
      check("rst2_relaunch_slot0", bus.tx_frame, frames[0]);
      check("rst2_no_report", 72'(respPulses), 72'(expReports));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
